// File: rtl/roc_aer_pkg.sv
// Shared types and default constants for the rank-order-coding AER output path.
package roc_aer_pkg;

  localparam int unsigned AER_ADDR_BITS   = 10;
  localparam int unsigned AER_SYNC_STAGES = 2;
  localparam int unsigned AER_CNT_BITS    = 10;

  // 4-phase handshake sequencing on the AER output link
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StReqHi,
    StWaitAckLo
  } aer_state_t;

endpackage

// File: rtl/roc_sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous level signal.
module roc_sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/roc_aer_out_ctrl.sv
// AER output controller: takes sorted pixel indices from the rank-order encoder and
// drives them onto the 4-phase AER link of the SNN core, throttling the encoder via
// AERIN_CTRL_BUSY, counting completed events per image and flagging overruns.
// Optional: define ROC_AER_ACK_TIMEOUT_EN to add an ACK wait limit (TIMEOUT_CYCLES)
// and the sticky ACK_TIMEOUT_ERR output.
module roc_aer_out_ctrl
  import roc_aer_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = AER_ADDR_BITS,
  parameter int unsigned SYNC_STAGES    = AER_SYNC_STAGES,
  parameter int unsigned CNT_BITS       = AER_CNT_BITS
`ifdef ROC_AER_ACK_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 NEW_IMAGE,
  input  logic [ADDR_BITS-1:0] NEXT_INDEX,
  input  logic                 FOUND_NEXT_INDEX,
  input  logic                 ENCODER_RDY,
  output logic                 AERIN_CTRL_BUSY,
  output logic [ADDR_BITS-1:0] AEROUT_ADDR,
  output logic                 AEROUT_REQ,
  input  logic                 AEROUT_ACK,
  output logic [CNT_BITS-1:0]  EVENT_COUNT,
  output logic                 IMAGE_DONE,
  output logic                 OVERRUN_ERR
`ifdef ROC_AER_ACK_TIMEOUT_EN
  ,output logic                ACK_TIMEOUT_ERR
`endif
);

  aer_state_t state_q;
  logic       ack_s;
  // Set when an event completes; lets IMAGE_DONE fire once per finished image
  logic       armed_q;

`ifdef ROC_AER_ACK_TIMEOUT_EN
  localparam int unsigned ToBits = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToBits-1:0] to_cnt_q;
`endif

  roc_sync_ff #(
    .Stages(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .d_i   (AEROUT_ACK),
    .q_o   (ack_s)
  );

  // Handshake FSM with all outputs registered; later assignments take priority
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= StIdle;
      AEROUT_ADDR     <= '0;
      AEROUT_REQ      <= 1'b0;
      AERIN_CTRL_BUSY <= 1'b0;
      EVENT_COUNT     <= '0;
      IMAGE_DONE      <= 1'b0;
      OVERRUN_ERR     <= 1'b0;
      armed_q         <= 1'b0;
`ifdef ROC_AER_ACK_TIMEOUT_EN
      to_cnt_q        <= '0;
      ACK_TIMEOUT_ERR <= 1'b0;
`endif
    end else begin
      IMAGE_DONE <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (FOUND_NEXT_INDEX) begin
            AEROUT_ADDR     <= NEXT_INDEX;
            AERIN_CTRL_BUSY <= 1'b1;
            state_q         <= StSetup;
          end
        end
        StSetup: begin
          // Hold off while a stale ACK from the core is still high
          if (!ack_s) begin
            AEROUT_REQ <= 1'b1;
            state_q    <= StReqHi;
          end
        end
        StReqHi: begin
          if (ack_s) begin
            AEROUT_REQ <= 1'b0;
            state_q    <= StWaitAckLo;
          end
        end
        StWaitAckLo: begin
          if (!ack_s) begin
            AERIN_CTRL_BUSY <= 1'b0;
            armed_q         <= 1'b1;
            state_q         <= StIdle;
            if (EVENT_COUNT != {CNT_BITS{1'b1}}) begin
              EVENT_COUNT <= EVENT_COUNT + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Strobes outside IDLE are dropped; the in-flight event carries on
      if (FOUND_NEXT_INDEX && (state_q != StIdle)) begin
        OVERRUN_ERR <= 1'b1;
      end

      if ((state_q == StIdle) && ENCODER_RDY && armed_q) begin
        IMAGE_DONE <= 1'b1;
        armed_q    <= 1'b0;
      end

`ifdef ROC_AER_ACK_TIMEOUT_EN
      // Abandon the event if the core never completes the handshake
      if ((state_q == StReqHi) || (state_q == StWaitAckLo)) begin
        if (to_cnt_q == ToBits'(TIMEOUT_CYCLES - 1)) begin
          ACK_TIMEOUT_ERR <= 1'b1;
          AEROUT_REQ      <= 1'b0;
          AERIN_CTRL_BUSY <= 1'b0;
          EVENT_COUNT     <= EVENT_COUNT;
          armed_q         <= armed_q;
          state_q         <= StIdle;
          to_cnt_q        <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
`endif

      // Image start clears bookkeeping but never aborts the handshake
      if (NEW_IMAGE) begin
        EVENT_COUNT <= '0;
        OVERRUN_ERR <= 1'b0;
        armed_q     <= 1'b0;
`ifdef ROC_AER_ACK_TIMEOUT_EN
        ACK_TIMEOUT_ERR <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_roc_aer_out_ctrl.sv
// Directed bench for roc_aer_out_ctrl; a queue holds the addresses expected on the link.
module tb_roc_aer_out_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 10;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          new_image   = 1'b0;
  logic [AW-1:0] next_index  = '0;
  logic          found       = 1'b0;
  logic          encoder_rdy = 1'b0;
  logic          ack         = 1'b0;
  logic          busy;
  logic [AW-1:0] addr;
  logic          req;
  logic [CW-1:0] count;
  logic          done;
  logic          overrun;
`ifdef ROC_AER_ACK_TIMEOUT_EN
  logic          to_err;
`endif

  int            total     = 0;
  int            bad       = 0;
  int            exp_count = 0;
  int            pulses;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] image_idx[7];

  always #5 clk = ~clk;

  roc_aer_out_ctrl #(
    .ADDR_BITS     (AW),
    .SYNC_STAGES   (2),
    .CNT_BITS      (CW)
`ifdef ROC_AER_ACK_TIMEOUT_EN
    ,.TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .NEW_IMAGE       (new_image),
    .NEXT_INDEX      (next_index),
    .FOUND_NEXT_INDEX(found),
    .ENCODER_RDY     (encoder_rdy),
    .AERIN_CTRL_BUSY (busy),
    .AEROUT_ADDR     (addr),
    .AEROUT_REQ      (req),
    .AEROUT_ACK      (ack),
    .EVENT_COUNT     (count),
    .IMAGE_DONE      (done),
    .OVERRUN_ERR     (overrun)
`ifdef ROC_AER_ACK_TIMEOUT_EN
    ,.ACK_TIMEOUT_ERR(to_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // which=0 watches REQ, which=1 watches BUSY
  task automatic wait_level(input string tag, input bit which, input logic level);
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if ((which ? busy : req) === level) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_new_image();
    new_image = 1'b1;
    tick();
    new_image = 1'b0;
    exp_count = 0;
  endtask

  task automatic strobe(input logic [AW-1:0] idx);
    next_index = idx;
    found      = 1'b1;
    exp_q.push_back(idx);
    tick();
    found = 1'b0;
    check("busy_after_strobe", {31'd0, busy}, 32'd1);
    check("req_low_in_setup", {31'd0, req}, 32'd0);
  endtask

  // Core side sees REQ: the address on the link must be the oldest queued index
  task automatic req_phase();
    logic [AW-1:0] want;
    wait_level("req_rise", 1'b0, 1'b1);
    if (exp_q.size() == 0) begin
      check("unexpected_event", 32'd0, 32'd1);
    end else begin
      want = exp_q.pop_front();
      check("addr_on_req", {22'd0, addr}, {22'd0, want});
    end
  endtask

  // ACK 2 cycles after REQ seen, release 2 cycles after REQ falls
  task automatic ack_phase(input bit inject_overrun);
    if (inject_overrun) begin
      next_index = 10'd9;
      found      = 1'b1;
      tick();
      found = 1'b0;
      tick();
    end else begin
      tick();
      tick();
    end
    ack = 1'b1;
    tick();
    check("req_held_until_ack_s", {31'd0, req}, 32'd1);
    wait_level("req_fall", 1'b0, 1'b0);
    check("busy_while_ack_high", {31'd0, busy}, 32'd1);
    tick();
    tick();
    ack = 1'b0;
    wait_level("busy_fall", 1'b1, 1'b0);
    if (exp_count < 1023) exp_count++;
    check("event_count", {22'd0, count}, exp_count);
  endtask

  initial begin
    image_idx = '{10'd6, 10'd2, 10'd0, 10'd5, 10'd1, 10'd3, 10'd4};

    // Reset state
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", {22'd0, addr}, 32'd0);
    check("rst_count", {22'd0, count}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single event
    strobe(10'd37);
    check("addr_before_req", {22'd0, addr}, 32'd37);
    req_phase();
    ack_phase(1'b0);

    // Image of 7 events; ENCODER_RDY rises during the last one
    pulse_new_image();
    check("new_image_clears_count", {22'd0, count}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      strobe(image_idx[i]);
      if (i == 6) encoder_rdy = 1'b1;
      req_phase();
      if (i == 6) check("done_deferred", {31'd0, done}, 32'd0);
      ack_phase(1'b0);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check("image_done_pulses", pulses, 32'd1);
    check("image_count", {22'd0, count}, 32'd7);
    encoder_rdy = 1'b0;

    // Overrun: index 9 strobed while index 4 is in REQ_HI
    pulse_new_image();
    strobe(10'd4);
    req_phase();
    ack_phase(1'b1);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_count", {22'd0, count}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("dropped_no_req", {31'd0, req}, 32'd0);
    check("dropped_no_busy", {31'd0, busy}, 32'd0);
    pulse_new_image();
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    check("count_cleared", {22'd0, count}, 32'd0);

    // Stale ACK high when strobe arrives
    ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    strobe(10'd11);
    for (int i = 0; i < 5; i++) tick();
    check("stale_req_low", {31'd0, req}, 32'd0);
    check("stale_busy", {31'd0, busy}, 32'd1);
    ack = 1'b0;
    req_phase();
    ack_phase(1'b0);

`ifdef ROC_AER_ACK_TIMEOUT_EN
    // No ACK at all: event abandoned after 16 cycles in REQ_HI
    strobe(10'd30);
    req_phase();
    for (int i = 0; i < 20; i++) tick();
    check("timeout_err", {31'd0, to_err}, 32'd1);
    check("timeout_req", {31'd0, req}, 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_count", {22'd0, count}, exp_count);
`endif

    // Reset while REQ is high
    strobe(10'd20);
    req_phase();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, req}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_count", {22'd0, count}, 32'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    exp_count = 0;
    tick();
    strobe(10'd21);
    req_phase();
    ack_phase(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
